// File: rtl/axi_burst_writer.sv
// Single-outstanding AXI write master: one (address, length) request plus a beat stream in, AW/W/B out.
// Define AXI_WR_OVERLAP_EN to run the AW and W channels concurrently instead of AW strictly first.
module axi_burst_writer #(
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned ADDR_WIDTH = 33,
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned WR_ID      = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   wr_addr_in,
   input  logic [7:0]              wr_len_in,
   input  logic                    wr_info_valid_in,
   output logic                    wr_info_rdy_out,
   input  logic [DATA_WIDTH-1:0]   wr_data_in,
   input  logic                    wr_data_valid_in,
   output logic                    wr_data_rdy_out,
   output logic                    wr_done_out,
   output logic                    wr_err_out,
   input  logic                    axi_awready_in,
   output logic [ID_WIDTH-1:0]     axi_awid_out,
   output logic [ADDR_WIDTH-1:0]   axi_awaddr_out,
   output logic [7:0]              axi_awlen_out,
   output logic                    axi_awvalid_out,
   input  logic                    axi_wready_in,
   output logic [DATA_WIDTH-1:0]   axi_wdata_out,
   output logic [DATA_WIDTH/8-1:0] axi_wstrb_out,
   output logic                    axi_wlast_out,
   output logic                    axi_wvalid_out,
   input  logic [ID_WIDTH-1:0]     axi_bid_in,
   input  logic [1:0]              axi_bresp_in,
   input  logic                    axi_bvalid_in,
   output logic                    axi_bready_out
);

   localparam int unsigned LEN_W  = 8;
   localparam int unsigned OFS_W  = 5;
   localparam int unsigned STRB_W = DATA_WIDTH / 8;

`ifdef AXI_WR_OVERLAP_EN
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR_DATA = 2'd1, RESP = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;
`endif

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      cnt_q;
   logic                  info_rdy_q;
   logic                  awvalid_q;
   logic                  bready_q;
   logic                  done_q;
   logic                  err_q;

   logic info_hs, aw_hs, w_active, w_hs, last_beat, last_hs, b_hs;

   // Response ID and the sub-beat address bits carry no information for this master.
   logic unused_inputs;
   assign unused_inputs = ^{axi_bid_in, wr_addr_in[OFS_W-1:0]};

   assign info_hs   = info_rdy_q & wr_info_valid_in;
   assign aw_hs     = awvalid_q & axi_awready_in;
   assign w_hs      = w_active & wr_data_valid_in & axi_wready_in;
   assign last_beat = (cnt_q == len_q);
   assign last_hs   = w_hs & last_beat;
   assign b_hs      = bready_q & axi_bvalid_in;

`ifdef AXI_WR_OVERLAP_EN
   logic aw_done_q, w_done_q;

   assign w_active = (state_q == ADDR_DATA) && !w_done_q;

   // Completion flags for the two concurrent channels; cleared when a new request is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else if (info_hs) begin
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         if (aw_hs)   aw_done_q <= 1'b1;
         if (last_hs) w_done_q  <= 1'b1;
      end
   end
`else
   assign w_active = (state_q == DATA);
`endif

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
`ifdef AXI_WR_OVERLAP_EN
         IDLE:      if (info_hs) state_d = ADDR_DATA;
         ADDR_DATA: if ((aw_done_q || aw_hs) && (w_done_q || last_hs)) state_d = RESP;
`else
         IDLE:      if (info_hs) state_d = ADDR;
         ADDR:      if (aw_hs)   state_d = DATA;
         DATA:      if (last_hs) state_d = RESP;
`endif
         RESP:      if (b_hs)    state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         info_rdy_q <= 1'b0;
         awvalid_q  <= 1'b0;
         bready_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         info_rdy_q <= (state_d == IDLE);
         bready_q   <= (state_d == RESP);
         done_q     <= b_hs;
         err_q      <= b_hs && (axi_bresp_in != 2'b00);
         if (info_hs) begin
            addr_q    <= {wr_addr_in[ADDR_WIDTH-1:OFS_W], OFS_W'(0)};
            len_q     <= wr_len_in;
            cnt_q     <= '0;
            awvalid_q <= 1'b1;
         end else if (aw_hs) begin
            awvalid_q <= 1'b0;
         end
         // Counter parks at the final beat index so a 256-beat burst never wraps.
         if (w_hs && !last_beat) cnt_q <= cnt_q + LEN_W'(1);
      end
   end

   assign wr_info_rdy_out = info_rdy_q;
   assign wr_done_out     = done_q;
   assign wr_err_out      = err_q;
   assign axi_awid_out    = ID_WIDTH'(WR_ID);
   assign axi_awaddr_out  = addr_q;
   assign axi_awlen_out   = len_q;
   assign axi_awvalid_out = awvalid_q;
   assign axi_bready_out  = bready_q;

   // W channel is a gated pass-through of the client stream.
   assign axi_wdata_out   = w_active ? wr_data_in : '0;
   assign axi_wvalid_out  = w_active & wr_data_valid_in;
   assign wr_data_rdy_out = w_active & axi_wready_in;
   assign axi_wlast_out   = w_active & last_beat;
   assign axi_wstrb_out   = {STRB_W{1'b1}};

endmodule

// File: tb/tb_axi_burst_writer.sv
// Directed/randomized bench for axi_burst_writer (default, non-overlapped build).
// A small AXI slave and client model run cycle by cycle inside each burst task.
module tb_axi_burst_writer;

   logic         clk = 1'b0;
   logic         rst;
   logic [32:0]  wr_addr_in;
   logic [7:0]   wr_len_in;
   logic         wr_info_valid_in;
   logic         wr_info_rdy_out;
   logic [255:0] wr_data_in;
   logic         wr_data_valid_in;
   logic         wr_data_rdy_out;
   logic         wr_done_out;
   logic         wr_err_out;
   logic         axi_awready_in;
   logic [7:0]   axi_awid_out;
   logic [32:0]  axi_awaddr_out;
   logic [7:0]   axi_awlen_out;
   logic         axi_awvalid_out;
   logic         axi_wready_in;
   logic [255:0] axi_wdata_out;
   logic [31:0]  axi_wstrb_out;
   logic         axi_wlast_out;
   logic         axi_wvalid_out;
   logic [7:0]   axi_bid_in;
   logic [1:0]   axi_bresp_in;
   logic         axi_bvalid_in;
   logic         axi_bready_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_burst_writer dut (
      .clk(clk), .rst(rst),
      .wr_addr_in(wr_addr_in), .wr_len_in(wr_len_in),
      .wr_info_valid_in(wr_info_valid_in), .wr_info_rdy_out(wr_info_rdy_out),
      .wr_data_in(wr_data_in), .wr_data_valid_in(wr_data_valid_in), .wr_data_rdy_out(wr_data_rdy_out),
      .wr_done_out(wr_done_out), .wr_err_out(wr_err_out),
      .axi_awready_in(axi_awready_in), .axi_awid_out(axi_awid_out), .axi_awaddr_out(axi_awaddr_out),
      .axi_awlen_out(axi_awlen_out), .axi_awvalid_out(axi_awvalid_out),
      .axi_wready_in(axi_wready_in), .axi_wdata_out(axi_wdata_out), .axi_wstrb_out(axi_wstrb_out),
      .axi_wlast_out(axi_wlast_out), .axi_wvalid_out(axi_wvalid_out),
      .axi_bid_in(axi_bid_in), .axi_bresp_in(axi_bresp_in), .axi_bvalid_in(axi_bvalid_in),
      .axi_bready_out(axi_bready_out)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] ctl_bits();
      return {axi_awvalid_out, axi_wvalid_out, wr_data_rdy_out, axi_bready_out,
              wr_done_out, wr_err_out, axi_wlast_out};
   endfunction

   // One request end to end. wmode: 0 wready always 1, 1 toggling, 2 random.
   // rst_after >= 0 pulses rst once that many beats have transferred and abandons the burst.
   task automatic run_burst(input logic [32:0] addr, input int len, input int aw_wait, input int wmode,
                            input logic [1:0] bresp, input int b_wait, input int rst_after);
      logic [255:0] beats [256];
      logic [32:0]  exp_addr, aw_addr_first;
      logic [7:0]   aw_len_first;
      int k = 0, aw_cnt = 0, b_cnt = 0, info_cyc = 0, stage = 0;
      bit info_done = 0, aw_seen = 0, aw_done = 0, early_w = 0, aw_moved = 0, finished = 0, aborted = 0;

      exp_addr = addr - (addr % 33'd32);
      for (int i = 0; i <= len; i++)
         for (int j = 0; j < 8; j++) beats[i][j*32 +: 32] = $urandom;

      wr_addr_in       = addr;
      wr_len_in        = 8'(len);
      wr_info_valid_in = 1'b1;
      wr_data_in       = beats[0];
      wr_data_valid_in = 1'b1;
      axi_awready_in   = (aw_wait == 0);
      axi_wready_in    = 1'b1;
      axi_bvalid_in    = 1'b0;
      axi_bresp_in     = 2'b00;

      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         @(negedge clk);
         if ((axi_wvalid_out || wr_data_rdy_out) && !aw_done) early_w = 1;
         if (axi_wvalid_out && axi_wready_in) begin
            if (k <= len) begin
               check($sformatf("wdata[%0d]", k), axi_wdata_out, beats[k]);
               check($sformatf("wlast[%0d]", k), axi_wlast_out, k == len);
            end
            k++;
         end
         if (!info_done && wr_info_valid_in && wr_info_rdy_out) begin
            info_done = 1;
            info_cyc  = cyc;
            check("awvalid_at_info_hs", axi_awvalid_out, 0);
         end
         if (axi_awvalid_out && !aw_done) begin
            if (!aw_seen) begin
               aw_seen = 1;
               aw_addr_first = axi_awaddr_out;
               aw_len_first  = axi_awlen_out;
               check("aw_latency", cyc, info_cyc + 1);
            end else if (axi_awaddr_out !== aw_addr_first || axi_awlen_out !== aw_len_first) begin
               aw_moved = 1;
            end
            if (axi_awready_in) begin
               aw_done = 1;
               check("awaddr", axi_awaddr_out, exp_addr);
               check("awlen", axi_awlen_out, len);
               check("awid", axi_awid_out, 0);
               check("wstrb", axi_wstrb_out, 32'hFFFF_FFFF);
               check("aw_stable", aw_moved, 0);
            end
         end
         case (stage)
            2: begin
               check("done_width", wr_done_out, 0);
               finished = 1;
            end
            1: begin
               check("done_pulse", wr_done_out, 1);
               check("done_err", wr_err_out, bresp != 2'b00);
               check("rdy_with_done", wr_info_rdy_out, 1);
               stage = 2;
            end
            default: if (wr_done_out) check("done_before_b", wr_done_out, 0);
         endcase
         if (stage == 0 && axi_bvalid_in && axi_bready_out) stage = 1;

         @(posedge clk);
         #1;
         if (rst_after >= 0 && k == rst_after && !aborted) begin
            rst = 1'b1;
            wr_info_valid_in = 1'b0;
            wr_data_valid_in = 1'b0;
            axi_awready_in   = 1'b0;
            axi_bvalid_in    = 1'b0;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check("abort_ctl_zero", ctl_bits(), 0);
            check("abort_rdy", wr_info_rdy_out, 0);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("abort_no_done", {wr_done_out, axi_awvalid_out, axi_bready_out}, 0);
            end
            @(posedge clk);
            #1;
            aborted  = 1;
            finished = 1;
         end else begin
            if (info_done) wr_info_valid_in = 1'b0;
            wr_data_valid_in = (k <= len);
            if (k <= len) wr_data_in = beats[k];
            if (aw_done) axi_awready_in = 1'b0;
            else if (aw_seen) begin
               aw_cnt++;
               axi_awready_in = (aw_cnt >= aw_wait);
            end
            case (wmode)
               0:       axi_wready_in = 1'b1;
               1:       axi_wready_in = ~axi_wready_in;
               default: axi_wready_in = 1'($urandom_range(0, 1));
            endcase
            if (stage > 0) axi_bvalid_in = 1'b0;
            else if (k > len) begin
               if (b_cnt >= b_wait) begin
                  axi_bvalid_in = 1'b1;
                  axi_bresp_in  = bresp;
               end
               b_cnt++;
            end
         end
      end

      if (!finished) check("burst_timeout", 0, 1);
      if (!aborted) begin
         check("beat_count", k, len + 1);
         check("no_w_before_aw", early_w, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      wr_addr_in = '0; wr_len_in = '0; wr_info_valid_in = 1'b0;
      wr_data_in = '0; wr_data_valid_in = 1'b0;
      axi_awready_in = 1'b0; axi_wready_in = 1'b0;
      axi_bid_in = 8'h5A; axi_bresp_in = 2'b00; axi_bvalid_in = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rdy", wr_info_rdy_out, 0);
      check("rst_ctl_zero", ctl_bits(), 0);
      check("rst_addr_len", {axi_awaddr_out, axi_awlen_out}, 0);
      check("rst_awid", axi_awid_out, 0);
      check("rst_wstrb", axi_wstrb_out, 32'hFFFF_FFFF);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_rdy", wr_info_rdy_out, 1);

      run_burst(33'h1000_0020, 3, 0, 0, 2'b00, 0, -1);
      run_burst(33'h0000_003F, 0, 0, 0, 2'b00, 0, -1);
      run_burst(33'($urandom), 7, 5, 1, 2'b00, 2, -1);
      run_burst(33'($urandom), 2, 0, 0, 2'b10, 0, -1);

      // A response with no burst outstanding must be ignored.
      axi_bvalid_in = 1'b1;
      axi_bresp_in  = 2'b10;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stray_b", {wr_done_out, wr_err_out, axi_bready_out}, 0);
      end
      @(posedge clk);
      #1 axi_bvalid_in = 1'b0;

      run_burst(33'($urandom), 15, 0, 0, 2'b00, 0, 2);
      run_burst(33'($urandom), 1, 0, 0, 2'b00, 0, -1);

      for (int n = 0; n < 6; n++)
         run_burst({1'($urandom), 32'($urandom)}, $urandom_range(0, 31), $urandom_range(0, 3), 2,
                   2'($urandom), $urandom_range(0, 3), -1);

      run_burst(33'($urandom), 255, 1, 2, 2'b00, 1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
